// File: rtl/csr_config_sequencer.sv
// csr_config_sequencer: PS start/done handshake front-end for the MXU control unit.
// Fetches a 4-byte job descriptor from CSR BRAM, validates it, runs the job under a watchdog, writes status back.
module csr_config_sequencer #(
  parameter int unsigned ADDRESS_SIZE_CSR = 32,
  parameter int unsigned DATA_WIDTH_CSR   = 8,
  parameter int unsigned CSR_BASE         = 0,
  parameter int unsigned ROWS             = 3,
  parameter int unsigned COLUMNS          = 3,
  parameter int unsigned PREC_W           = 4,
  parameter int unsigned MAX_PREC_CODE    = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cs_start,
  input  logic                        cs_continue,
  output logic                        cs_ready,
  output logic                        cs_idle,
  output logic                        cs_done,
  output logic                        csr_ce,
  output logic                        csr_we,
  output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
  output logic [DATA_WIDTH_CSR-1:0]   csr_din,
  input  logic [DATA_WIDTH_CSR-1:0]   csr_dout,
  output logic                        cfg_valid,
  input  logic                        run_done,
  output logic [PREC_W-1:0]           data_precision,
  output logic [$clog2(ROWS):0]       active_rows,
  output logic [$clog2(COLUMNS):0]    active_cols,
  output logic                        enable_chain,
  output logic [1:0]                  enable_fp_unit,
  output logic [2:0]                  status,
  output logic [3:0]                  state_out
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_SIZE_CSR-1:0] BASE_ADDR = ADDRESS_SIZE_CSR'(CSR_BASE);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_CHECK = 4'd2,
    S_RUN   = 4'd3,
    S_WB    = 4'd4,
    S_DONE  = 4'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [2:0]                r_fetch_cnt;
  logic [WD_W-1:0]           r_wd_cnt;
  logic [DATA_WIDTH_CSR-1:0] r_byte0;
  logic [DATA_WIDTH_CSR-1:0] r_byte1;
  logic [DATA_WIDTH_CSR-1:0] r_byte2;
  logic [2:0]                r_byte3;
  logic [2:0]                r_status;
  logic                      w_cfg_err;
  logic                      w_wd_expired;

  // Full-width compares: an out-of-range byte must not alias into range by truncation.
  assign w_cfg_err = (32'(r_byte0) > MAX_PREC_CODE) ||
                     (32'(r_byte1) == 32'd0) || (32'(r_byte1) > ROWS) ||
                     (32'(r_byte2) == 32'd0) || (32'(r_byte2) > COLUMNS);
  assign w_wd_expired = (r_wd_cnt == WD_LAST);

  assign data_precision = r_byte0[PREC_W-1:0];
  assign active_rows    = r_byte1[$clog2(ROWS):0];
  assign active_cols    = r_byte2[$clog2(COLUMNS):0];
  assign enable_chain   = r_byte3[0];
  assign enable_fp_unit = r_byte3[2:1];
  assign status         = r_status;
  assign state_out      = r_state;
  assign cs_idle        = (r_state == S_IDLE);
  assign cs_done        = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_cnt <= '0;
      r_wd_cnt    <= '0;
      r_byte0     <= '0;
      r_byte1     <= '0;
      r_byte2     <= '0;
      r_byte3     <= '0;
      r_status    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (cs_start) begin
            r_status    <= '0;
            r_fetch_cnt <= '0;
          end
        end
        S_FETCH: begin
          r_fetch_cnt <= r_fetch_cnt + 3'd1;
          // BRAM data lags the issued address by one cycle.
          case (r_fetch_cnt)
            3'd1:    r_byte0 <= csr_dout;
            3'd2:    r_byte1 <= csr_dout;
            3'd3:    r_byte2 <= csr_dout;
            3'd4:    r_byte3 <= csr_dout[2:0];
            default: ;
          endcase
        end
        S_CHECK: begin
          r_wd_cnt <= '0;
          if (w_cfg_err) r_status <= 3'b010;
        end
        S_RUN: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (run_done)          r_status <= 3'b001;
          else if (w_wd_expired) r_status <= 3'b100;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    cs_ready    = 1'b0;
    csr_ce      = 1'b0;
    csr_we      = 1'b0;
    csr_address = '0;
    csr_din     = '0;
    cfg_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cs_start) begin
          w_next   = S_FETCH;
          cs_ready = ~reset;
        end
      end
      S_FETCH: begin
        if (r_fetch_cnt == 3'd4) begin
          w_next = S_CHECK;
        end else begin
          csr_ce      = 1'b1;
          csr_address = BASE_ADDR + ADDRESS_SIZE_CSR'(r_fetch_cnt);
        end
      end
      S_CHECK: w_next = w_cfg_err ? S_WB : S_RUN;
      S_RUN: begin
        cfg_valid = (r_wd_cnt == '0);
        if (run_done || w_wd_expired) w_next = S_WB;
      end
      S_WB: begin
        csr_ce      = 1'b1;
        csr_we      = 1'b1;
        csr_address = BASE_ADDR + ADDRESS_SIZE_CSR'(4);
        csr_din     = DATA_WIDTH_CSR'(r_status);
        w_next      = S_DONE;
      end
      S_DONE: begin
        if (cs_continue) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Keep a BRAM access from landing on the edge that applies reset.
    if (reset) begin
      csr_ce = 1'b0;
      csr_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_config_sequencer.sv
// Randomized self-checking bench for csr_config_sequencer with a CSR BRAM model and a job-level reference model.
module tb_csr_config_sequencer;
  localparam int unsigned BASE = 32'h100;
  localparam int unsigned TO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_start = 1'b0;
  logic        cs_continue = 1'b0;
  logic        run_done = 1'b0;
  logic        cs_ready, cs_idle, cs_done, csr_ce, csr_we, cfg_valid, enable_chain;
  logic [31:0] csr_address;
  logic [7:0]  csr_din;
  logic [7:0]  csr_dout = 8'h00;
  logic [3:0]  data_precision;
  logic [2:0]  active_rows, active_cols;
  logic [1:0]  enable_fp_unit;
  logic [2:0]  status;
  logic [3:0]  state_out;

  csr_config_sequencer #(
    .ADDRESS_SIZE_CSR(32), .DATA_WIDTH_CSR(8), .CSR_BASE(BASE), .ROWS(3), .COLUMNS(3),
    .PREC_W(4), .MAX_PREC_CODE(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .cs_start(cs_start), .cs_continue(cs_continue),
    .cs_ready(cs_ready), .cs_idle(cs_idle), .cs_done(cs_done),
    .csr_ce(csr_ce), .csr_we(csr_we), .csr_address(csr_address), .csr_din(csr_din),
    .csr_dout(csr_dout), .cfg_valid(cfg_valid), .run_done(run_done),
    .data_precision(data_precision), .active_rows(active_rows), .active_cols(active_cols),
    .enable_chain(enable_chain), .enable_fp_unit(enable_fp_unit), .status(status),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  always @(posedge clk) begin
    if (csr_ce) begin
      if (csr_we) mem[csr_address[8:0]] <= csr_din;
      else        csr_dout <= mem[csr_address[8:0]];
    end
  end

  int unsigned cyc = 0;
  int unsigned ready_cnt, ready_cyc, cfgv_cnt, cfgv_cyc, run_cyc, done_cyc;
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (cs_ready) begin ready_cnt++; ready_cyc = cyc; end
    if (cfg_valid) begin cfgv_cnt++; cfgv_cyc = cyc; end
    if (state_out == 4'd3) run_cyc++;
    if (cs_done) done_cyc++;
    if (csr_ce && !csr_we) rd_q.push_back(csr_address);
    if (csr_ce && csr_we) begin wa_q.push_back(csr_address); wd_q.push_back(csr_din); end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] last_status = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Job outcome from the descriptor rules and the cycle index (0-based within RUN) of run_done.
  function automatic logic [2:0] model_status(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input int done_at);
    if (b0 > 8'd4 || b1 < 8'd1 || b1 > 8'd3 || b2 < 8'd1 || b2 > 8'd3) return 3'b010;
    if (done_at >= 0 && done_at < int'(TO)) return 3'b001;
    return 3'b100;
  endfunction

  task automatic do_job(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int done_at, input int cont_delay,
                        input bit hold, input bit stray);
    logic [2:0] es;
    int exp_run;
    int k;
    int rc;
    es = model_status(b0, b1, b2, done_at);
    exp_run = (es == 3'b010) ? 0 : ((es == 3'b001) ? done_at + 1 : int'(TO));
    mem[BASE] = b0; mem[BASE+1] = b1; mem[BASE+2] = b2; mem[BASE+3] = b3;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    ready_cnt = 0; ready_cyc = 0; cfgv_cnt = 0; cfgv_cyc = 0; run_cyc = 0; done_cyc = 0;
    check("idle_before", {31'd0, cs_idle}, 32'd1);
    cs_start = 1'b1;
    k = 0;
    rc = -1;
    while (!cs_done && k < 100) begin
      if (k > 0) cs_start = hold ? 1'b1 : (stray ? 1'($urandom_range(0, 1)) : 1'b0);
      run_done = 1'b0;
      if (cfg_valid) rc = 0;
      else if (rc >= 0) rc++;
      if (done_at >= 0 && rc == done_at) run_done = 1'b1;
      step();
      k++;
    end
    run_done = 1'b0;
    check("done_reached", {31'd0, cs_done}, 32'd1);
    if (!hold) cs_start = 1'b0;
    @(negedge clk);
    check("status", {29'd0, status}, {29'd0, es});
    check("cfg_fields", {19'd0, data_precision, active_rows, active_cols, enable_chain, enable_fp_unit},
          {19'd0, b0[3:0], b1[2:0], b2[2:0], b3[0], b3[2:1]});
    for (int j = 0; j < cont_delay; j++) step();
    cs_continue = 1'b1;
    step();
    cs_continue = 1'b0;
    check("ready_count", ready_cnt, 32'd1);
    check("read_count", rd_q.size(), 32'd4);
    for (int j = 0; j < 4 && j < rd_q.size(); j++) check("read_addr", rd_q[j], BASE + j);
    check("cfg_valid_count", cfgv_cnt, (es == 3'b010) ? 32'd0 : 32'd1);
    if (es != 3'b010) check("cfg_valid_latency", cfgv_cyc - ready_cyc, 32'd7);
    check("run_cycles", run_cyc, exp_run);
    check("wb_count", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check("wb_addr", wa_q[0], BASE + 4);
      check("wb_data", {24'd0, wd_q[0]}, {29'd0, es});
    end
    check("done_cycles", done_cyc, cont_delay + 1);
    check("idle_after", {30'd0, cs_idle, cs_done}, 32'd2);
    last_status = es;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, {28'd0, state_out}, 32'd0);
    check({tag, "_bram"}, {30'd0, csr_ce, csr_we}, 32'd0);
    check({tag, "_cfg_valid"}, {31'd0, cfg_valid}, 32'd0);
    check({tag, "_status"}, {29'd0, status}, 32'd0);
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3;
    int da;
    int k;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    reset = 1'b1;
    step();
    step();
    check("rst_idle", {31'd0, cs_idle}, 32'd1);
    check("rst_outs", {27'd0, cs_ready, cs_done, csr_ce, csr_we, cfg_valid}, 32'd0);
    check("rst_cfg", {19'd0, data_precision, active_rows, active_cols, enable_chain, enable_fp_unit}, 32'd0);
    check_reset_state("rst");
    reset = 1'b0;
    step();

    do_job(8'd2, 8'd3, 8'd3, 8'h05, 10, 2, 1'b0, 1'b0);

    run_done = 1'b1;
    step();
    run_done = 1'b0;
    check("stray_run_done_state", {28'd0, state_out}, 32'd0);
    check("stray_run_done_status", {29'd0, status}, {29'd0, last_status});

    do_job(8'd2, 8'd4, 8'd3, 8'h05, 3, 1, 1'b0, 1'b0);
    do_job(8'd9, 8'd3, 8'd3, 8'h05, 3, 0, 1'b0, 1'b0);
    do_job(8'd4, 8'd1, 8'd1, 8'h02, -1, 0, 1'b0, 1'b0);
    do_job(8'd0, 8'd2, 8'd3, 8'h07, 15, 1, 1'b0, 1'b0);
    do_job(8'd1, 8'd3, 8'd2, 8'h01, 16, 0, 1'b0, 1'b0);

    mem[BASE] = 8'd1; mem[BASE+1] = 8'd2; mem[BASE+2] = 8'd2; mem[BASE+3] = 8'd0;
    cs_start = 1'b1;
    step();
    cs_start = 1'b0;
    step();
    step();
    check("fetch_i2_addr", csr_address, BASE + 2);
    reset = 1'b1;
    step();
    check_reset_state("rst_fetch");
    reset = 1'b0;
    step();
    check("rst_fetch_stays_idle", {28'd0, state_out}, 32'd0);

    mem[BASE+1] = 8'd0;
    mem[BASE+4] = 8'hAA;
    cs_start = 1'b1;
    step();
    cs_start = 1'b0;
    k = 0;
    while (state_out != 4'd4 && k < 30) begin step(); k++; end
    check("reach_wb", {28'd0, state_out}, 32'd4);
    reset = 1'b1;
    step();
    check_reset_state("rst_wb");
    reset = 1'b0;
    step();
    check("rst_wb_no_write", {24'd0, mem[BASE+4]}, 32'h0000_00AA);
    last_status = 3'b000;

    do_job(8'd3, 8'd3, 8'd1, 8'h04, 5, 0, 1'b1, 1'b0);
    do_job(8'd1, 8'd2, 8'd3, 8'h03, 2, 1, 1'b1, 1'b0);
    do_job(8'd2, 8'd1, 8'd2, 8'h06, 7, 0, 1'b0, 1'b0);
    do_job(8'd2, 8'd2, 8'd2, 8'h01, 12, 2, 1'b0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      b0 = 8'($urandom_range(0, 6));
      b1 = 8'($urandom_range(0, 4));
      b2 = 8'($urandom_range(0, 4));
      b3 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b1 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b0 = 8'($urandom_range(0, 255));
      da = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 18));
      do_job(b0, b1, b2, b3, da, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cs_start = 1'b0;
    step();
    step();
    check("final_idle", {28'd0, state_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: simulation did not complete within the time limit");
    $fatal(1, "simulation time limit exceeded");
  end
endmodule
